// File: rtl/phase0_pkg.sv
// Shared types and helpers for the phase0 lookup arbiter: default BRAM widths,
// the in-flight lookup tag and a one-hot decoder for requester indices.
package phase0_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 16;
  localparam int DEFAULT_DATA_WIDTH = 16;

  // Tag ids are sized for the largest supported requester count; callers
  // truncate the decoded vector down to their own NUM_REQ.
  localparam int TAG_ID_WIDTH = 8;
  localparam int MAX_REQ      = 1 << TAG_ID_WIDTH;

  typedef struct packed {
    logic                    valid;
    logic [TAG_ID_WIDTH-1:0] id;
  } lookup_tag_t;

  function automatic logic [MAX_REQ-1:0] onehot_from_index(input logic [TAG_ID_WIDTH-1:0] idx);
    logic [MAX_REQ-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/phase0_lookup_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: searches from last_grant+1 upward
// (wrapping) and returns the first requester found as one-hot and index.
module rr_arbiter #(
  parameter  int NUM_REQ   = 4,
  localparam int IDX_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [IDX_WIDTH-1:0] last_grant,
  output logic [NUM_REQ-1:0]   grant,
  output logic [IDX_WIDTH-1:0] grant_idx
);

  always_comb begin
    logic                 found;
    logic [IDX_WIDTH-1:0] cand;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_WIDTH'((int'(last_grant) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/phase0_lookup_arbiter.sv
// Shares one synchronous-read phase0 BRAM between NUM_REQ requesters with
// round-robin arbitration, tagging each lookup so its result returns to its issuer.
module phase0_lookup_arbiter
  import phase0_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int RD_LATENCY = 1,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                          clka,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          bram_ena,
  output logic [ADDR_WIDTH-1:0]         bram_addra,
  input  logic [DATA_WIDTH-1:0]         bram_douta,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [DATA_WIDTH-1:0]         resp_data,
  output logic [CNT_WIDTH-1:0]          lookup_count
);

  localparam int IDX_WIDTH = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req_live;
  logic [NUM_REQ-1:0]   grant;
  logic [IDX_WIDTH-1:0] grant_idx;
  logic [IDX_WIDTH-1:0] last_grant;
  logic                 transfer;
  lookup_tag_t          tag_pipe [RD_LATENCY];
  lookup_tag_t          tag_last;

  // Nothing is granted while reset is held, so no lookup can slip in during reset.
  assign req_live = req_valid & {NUM_REQ{rst_n}};

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .req        (req_live),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  assign transfer  = |grant;
  assign req_ready = grant;
  assign bram_ena  = transfer;
  assign tag_last  = tag_pipe[RD_LATENCY-1];

  always_comb begin
    bram_addra = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) bram_addra = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  // Tag pipeline mirrors the BRAM read latency so the tag emerges with its data.
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= IDX_WIDTH'(NUM_REQ - 1);
      for (int s = 0; s < RD_LATENCY; s++) tag_pipe[s] <= '0;
    end else begin
      if (transfer) last_grant <= grant_idx;
      tag_pipe[0] <= '{valid: transfer, id: TAG_ID_WIDTH'(grant_idx)};
      for (int s = 1; s < RD_LATENCY; s++) tag_pipe[s] <= tag_pipe[s-1];
    end
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= '0;
      resp_data  <= '0;
    end else if (tag_last.valid) begin
      resp_valid <= NUM_REQ'(onehot_from_index(tag_last.id));
      resp_data  <= bram_douta;
    end else begin
      resp_valid <= '0;
    end
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      lookup_count <= '0;
    end else if (transfer && lookup_count != '1) begin
      lookup_count <= lookup_count + CNT_WIDTH'(1);
    end
  end

endmodule
